// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output Ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             busy_q;
  logic             done_q;
  logic             slice_s;
  logic             slice_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  assign slice_s  = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign slice_co = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  assign sum_d    = {slice_s, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE behaves like IDLE so a start there chains straight into the next add
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_a_q  <= A;
            op_b_q  <= B;
            carry_q <= Ci;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          carry_q <= slice_co;
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q     <= sum_d;
            co_q    <= slice_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB slice
            ovf_q   <= carry_q ^ slice_co;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S    = s_q;
  assign Co   = co_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one full-adder bit slice: sum = A^B^Ci, carry = A&B | A&Ci | B&Ci.
- Shifts the operands LSB-first through that slice, one bit per clock, and keeps the carry in a flip-flop between bits.
- Assembles the sum in a shift register and reports the result with a start/busy/done handshake.
- Sits directly around the combinational full-adder stage: it feeds A, B and Ci into the slice each cycle and consumes S and Co.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on rising clk.
- A  input  WIDTH  operand A; captured on the accepted start edge.
- B  input  WIDTH  operand B; captured on the accepted start edge.
- Ci  input  1  carry-in; captured on the accepted start edge.
- S  output  WIDTH  registered sum of the last completed addition.
- Co  output  1  registered carry-out of the last completed addition.
- busy  output  1  high while bits are being shifted.
- done  output  1  one-cycle pulse; S and Co are valid from this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - S=0, Co=0, busy=0, done=0.
  - state=IDLE.
  - Internal shift registers, carry flip-flop and bit counter all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures A, B and Ci into opA, opB and the carry flip-flop.
  - Clears the counter and moves to SHIFT.
- SHIFT, on each edge:
  - Bit slice inputs are opA[0], opB[0] and the carry flip-flop.
  - Slice sum shifts into the sum register at the MSB end; the register shifts right.
  - opA and opB shift right with 0 fill.
  - Carry flip-flop takes the slice carry.
  - Counter increments.
- Completion:
  - The edge that completes bit WIDTH-1 loads S from the sum register (including the final bit) and Co from the slice carry.
  - The same edge moves the FSM to DONE.
- busy=1 exactly in SHIFT, for WIDTH cycles.
- DONE: done=1 for one cycle, then the FSM returns to IDLE.
- DONE accepts start exactly as IDLE does, giving back-to-back operation:
  - done=1 and busy=1 never assert in the same cycle.
  - On a start accepted in DONE, the next state is SHIFT.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- start in SHIFT is ignored: no restart, and the operands are not recaptured.
- A, B and Ci may change freely after capture without affecting the running addition.
- S and Co keep the previous result during SHIFT and change only on the completion edge.
- Arithmetic:
  - {Co,S} = A + B + Ci, modulo 2^(WIDTH+1).
  - Operands are unsigned; no sign extension.
- rst asserted mid-operation aborts immediately to the reset values; no done pulse follows.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Adds output port Ovf, 1 bit, registered, reset 0.
  - On the completion edge, Ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). This is the two's-complement signed overflow.
  - Ovf is held until the next completion or reset.
- Without the macro: port Ovf and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- Basic: reset; start with A=8'h35, B=8'h4A, Ci=0 -> busy high 8 cycles, done pulse after edge 8, S=8'h7F, Co=0.
- Carry ripple: A=8'hFF, B=8'h01, Ci=0 -> S=8'h00, Co=1. Then A=8'hFF, B=8'h00, Ci=1 -> S=8'h00, Co=1.
- Ignored start: start with A=8'h10, B=8'h20, Ci=0; pulse start with A=8'hFF at cycle 3 -> result S=8'h30, Co=0; done occurs once, at the original time.
- Reset mid-operation: assert rst at cycle 4 of an addition -> S=0, Co=0, busy=0, done=0 immediately; no done pulse follows. The next addition 8'h01+8'h01 gives S=8'h02.
- Back-to-back: hold start high continuously with A=8'h80, B=8'h80, Ci=0 -> done pulses every 9 cycles, S=8'h00, Co=1; S is unchanged between pulses.
- SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> S=8'h80, Ovf=1. 8'hFF+8'h01 -> S=8'h00, Co=1, Ovf=0.
